score_bcd_sequencer: RTL and testbench

//  Multi-cycle binary-to-BCD sequencer feeding the on-screen score text overlay.
//  - Samples the 32-bit score once per frame, on frame_tick.
//  - Converts it to five BCD digits by shift-add-3 (double dabble), replacing per-pixel divide/modulo.
//  - Holds the digits stable for the whole frame so there is no mid-frame tearing.
//  - Sits between game/score logic and the ASCII-ROM text renderer; the renderer builds char codes as {3'b011, digit}.

---
 rtl/score_disp_pkg.sv | 17 +
 rtl/bcd_add3.sv | 10 +
 rtl/score_bcd_sequencer.sv | 125 ++++++++++++
 tb/tb_score_bcd_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_disp_pkg.sv
// Shared constants and FSM state type for the score display BCD path.
// The top module overrides DIGITS / BIN_W with its own parameters of the same name.
package score_disp_pkg;

  localparam int unsigned DIGITS    = 5;
  localparam int unsigned BCD_W     = 4 * DIGITS;
  localparam int unsigned BIN_W     = 17;
  localparam int unsigned ITER      = BIN_W;
  localparam logic [16:0] SAT_VALUE = 17'd99999;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more.
module bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  // 4-bit add; a corrected digit is at most 12, so no carry is produced.
  assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/score_bcd_sequencer.sv
// Once-per-frame binary-to-BCD score sequencer with saturation, one-deep tick pending
// and a leading-zero blank mask; outputs only change at the latch edge.
module score_bcd_sequencer #(
  parameter int unsigned SCORE_W    = 32,
  parameter int unsigned BIN_W      = 17,
  parameter int unsigned DIGITS     = 5,
  parameter bit          LEAD_BLANK = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_frame_tick,
  input  logic [SCORE_W-1:0]    i_score,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [DIGITS-1:0]     o_blank_mask,
  output logic                  o_digits_valid,
  output logic                  o_busy,
  output logic                  o_overflow
);
  import score_disp_pkg::*;

  localparam int unsigned      BcdW     = 4 * DIGITS;
  localparam int unsigned      CntW     = $clog2(BIN_W);
  localparam logic [SCORE_W-1:0] SatWide = SCORE_W'(SAT_VALUE);
  localparam logic [BIN_W-1:0] SatBin   = BIN_W'(SAT_VALUE);
  localparam logic [CntW-1:0]  CntLast  = CntW'(BIN_W - 1);
  localparam logic [DIGITS-1:0] BlankRst =
      LEAD_BLANK ? {{(DIGITS - 1){1'b1}}, 1'b0} : '0;

  state_e            r_state;
  logic [BIN_W-1:0]  r_bin;
  logic [BcdW-1:0]   r_scratch;
  logic [CntW-1:0]   r_cnt;
  logic              r_pending;
  logic              r_ovf;

  logic [BcdW-1:0]   w_adj;
  logic              w_sat;
  logic [BIN_W-1:0]  w_bin_load;
  logic [DIGITS-1:0] w_blank;
  logic              w_lead;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nib (r_scratch[4*g +: 4]),
      .o_nib (w_adj[4*g +: 4])
    );
  end

  // Saturation compare uses the full score width so huge scores never alias.
  assign w_sat      = (i_score > SatWide);
  assign w_bin_load = w_sat ? SatBin : i_score[BIN_W-1:0];

  always_comb begin
    w_blank = '0;
    w_lead  = 1'b1;
    if (LEAD_BLANK) begin
      for (int i = DIGITS - 1; i >= 1; i--) begin
        w_lead     = w_lead & (r_scratch[4*i +: 4] == 4'd0);
        w_blank[i] = w_lead;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= S_IDLE;
      r_bin          <= '0;
      r_scratch      <= '0;
      r_cnt          <= '0;
      r_pending      <= 1'b0;
      r_ovf          <= 1'b0;
      o_bcd          <= '0;
      o_blank_mask   <= BlankRst;
      o_digits_valid <= 1'b0;
      o_busy         <= 1'b0;
      o_overflow     <= 1'b0;
    end else begin
      o_digits_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_frame_tick) begin
            r_bin     <= w_bin_load;
            r_ovf     <= w_sat;
            r_scratch <= '0;
            r_cnt     <= '0;
            o_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (i_frame_tick) begin
            r_pending <= 1'b1;
          end
          {r_scratch, r_bin} <= {w_adj, r_bin} << 1;
          r_cnt              <= r_cnt + 1'b1;
          if (r_cnt == CntLast) begin
            r_state <= S_LATCH;
          end
        end
        S_LATCH: begin
          o_bcd          <= r_scratch;
          o_blank_mask   <= w_blank;
          o_overflow     <= r_ovf;
          o_digits_valid <= 1'b1;
          // A tick landing on this edge counts as pending: restart immediately.
          if (r_pending || i_frame_tick) begin
            r_bin     <= w_bin_load;
            r_ovf     <= w_sat;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_state   <= S_SHIFT;
          end else begin
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_sequencer.sv
// Self-checking bench for score_bcd_sequencer: scoreboard of expected digit sets
// popped on each digits_valid pulse, plus per-scenario timing checks.
module tb_score_bcd_sequencer;

  typedef struct packed {
    logic [19:0] bcd;
    logic [4:0]  blank;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        i_reset_n;
  logic        i_frame_tick;
  logic [31:0] i_score;
  logic [19:0] o_bcd;
  logic [4:0]  o_blank_mask;
  logic        o_digits_valid;
  logic        o_busy;
  logic        o_overflow;

  int   n_tests;
  int   n_fail;
  int   n_valid;
  exp_t sb[$];
  exp_t mon_e;

  score_bcd_sequencer u_dut (
    .i_clk          (clk),
    .i_reset_n      (i_reset_n),
    .i_frame_tick   (i_frame_tick),
    .i_score        (i_score),
    .o_bcd          (o_bcd),
    .o_blank_mask   (o_blank_mask),
    .o_digits_valid (o_digits_valid),
    .o_busy         (o_busy),
    .o_overflow     (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] s);
    exp_t        e;
    logic [31:0] v;
    logic        lead;
    e.ovf = (s > 32'd99999);
    v     = e.ovf ? 32'd99999 : s;
    for (int i = 0; i < 5; i++) begin
      e.bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    lead  = 1'b1;
    e.blank = '0;
    for (int i = 4; i >= 1; i--) begin
      lead       = lead & (e.bcd[4*i +: 4] == 4'd0);
      e.blank[i] = lead;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (o_digits_valid === 1'b1) begin
      n_valid++;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got bcd=%h blank=%b ovf=%b, required no pulse",
                 o_bcd, o_blank_mask, o_overflow);
      end else begin
        mon_e = sb.pop_front();
        if ({o_bcd, o_blank_mask, o_overflow} !== mon_e) begin
          n_fail++;
          $display("FAIL digits: got bcd=%h blank=%b ovf=%b, required bcd=%h blank=%b ovf=%b",
                   o_bcd, o_blank_mask, o_overflow, mon_e.bcd, mon_e.blank, mon_e.ovf);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Tick is high across exactly one rising edge (edge T); returns at the negedge after T.
  task automatic pulse_tick(input logic [31:0] s);
    @(negedge clk);
    i_score      = s;
    i_frame_tick = 1'b1;
    @(negedge clk);
    i_frame_tick = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 60; c++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d results outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    int v0;
    i_reset_n    = 1'b0;
    i_frame_tick = 1'b0;
    i_score      = '0;
    repeat (3) @(negedge clk);
    i_reset_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({o_bcd, o_blank_mask, o_busy, o_digits_valid, o_overflow} !== {20'h0, 5'b11110, 3'b000})
    begin
      n_fail++;
      $display("FAIL reset_values: got bcd=%h blank=%b busy=%b valid=%b ovf=%b, required 00000 11110 0 0 0",
               o_bcd, o_blank_mask, o_busy, o_digits_valid, o_overflow);
    end
    v0 = n_valid;
    repeat (25) @(negedge clk);
    n_tests++;
    if (n_valid !== v0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got %0d pulses busy=%b, required 0 pulses busy=0",
               n_valid - v0, o_busy);
    end
  endtask

  task automatic test_basic();
    sb.push_back(model(32'd12345));
    pulse_tick(32'd12345);
    n_tests++;
    if (o_busy !== 1'b1 || o_digits_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start: got busy=%b valid=%b, required 1 0", o_busy, o_digits_valid);
    end
    // Score changes mid-conversion must not disturb the result.
    i_score = 32'd77777;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      n_tests++;
      if (k < 18) begin
        if (o_busy !== 1'b1 || o_digits_valid !== 1'b0 || o_bcd !== 20'h0) begin
          n_fail++;
          $display("FAIL busy_window k=%0d: got busy=%b valid=%b bcd=%h, required 1 0 00000",
                   k, o_busy, o_digits_valid, o_bcd);
        end
      end else if (k == 18) begin
        if (o_busy !== 1'b0 || o_digits_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL valid_edge: got busy=%b valid=%b, required 0 1", o_busy, o_digits_valid);
        end
      end else begin
        if (o_busy !== 1'b0 || o_digits_valid !== 1'b0 || o_bcd !== 20'h12345) begin
          n_fail++;
          $display("FAIL after_valid: got busy=%b valid=%b bcd=%h, required 0 0 12345",
                   o_busy, o_digits_valid, o_bcd);
        end
      end
    end
  endtask

  task automatic test_values();
    logic [31:0] vals[6];
    vals = '{32'd7, 32'd0, 32'd100000, 32'hFFFF_FFFF, 32'd99999, 32'd100};
    for (int i = 0; i < 6; i++) begin
      sb.push_back(model(vals[i]));
      pulse_tick(vals[i]);
      drain("values");
    end
  endtask

  task automatic test_pending();
    int v0;
    v0 = n_valid;
    sb.push_back(model(32'd500));
    sb.push_back(model(32'd42));
    pulse_tick(32'd500);
    repeat (4) @(negedge clk);
    i_score      = 32'd42;
    i_frame_tick = 1'b1;
    repeat (2) @(negedge clk);
    i_frame_tick = 1'b0;
    repeat (12) @(negedge clk);
    n_tests++;
    if (o_digits_valid !== 1'b1 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pending_first: got valid=%b busy=%b, required 1 1", o_digits_valid, o_busy);
    end
    repeat (18) @(negedge clk);
    n_tests++;
    if (o_digits_valid !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pending_second: got valid=%b busy=%b, required 1 0", o_digits_valid, o_busy);
    end
    repeat (40) @(negedge clk);
    n_tests++;
    if (n_valid - v0 !== 2 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL pending_count: got %0d pulses, required 2", n_valid - v0);
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    sb.push_back(model(32'd11));
    sb.push_back(model(32'd22));
    pulse_tick(32'd11);
    repeat (17) @(negedge clk);
    i_score      = 32'd22;
    i_frame_tick = 1'b1;
    @(negedge clk);
    i_frame_tick = 1'b0;
    n_tests++;
    if (o_digits_valid !== 1'b1 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL latch_tick_first: got valid=%b busy=%b, required 1 1", o_digits_valid, o_busy);
    end
    repeat (18) @(negedge clk);
    n_tests++;
    if (o_digits_valid !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL latch_tick_second: got valid=%b busy=%b, required 1 0",
               o_digits_valid, o_busy);
    end
    drain("back_to_back");
  endtask

  task automatic test_reset_mid();
    int v0;
    v0 = n_valid;
    pulse_tick(32'd54321);
    repeat (8) @(negedge clk);
    i_reset_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({o_bcd, o_blank_mask, o_busy, o_digits_valid, o_overflow} !== {20'h0, 5'b11110, 3'b000})
    begin
      n_fail++;
      $display("FAIL reset_mid_values: got bcd=%h blank=%b busy=%b valid=%b ovf=%b, required 00000 11110 0 0 0",
               o_bcd, o_blank_mask, o_busy, o_digits_valid, o_overflow);
    end
    @(negedge clk);
    i_reset_n = 1'b1;
    repeat (30) @(negedge clk);
    n_tests++;
    if (n_valid !== v0 || o_busy !== 1'b0 || o_bcd !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: got %0d pulses busy=%b bcd=%h, required 0 0 00000",
               n_valid - v0, o_busy, o_bcd);
    end
    sb.push_back(model(32'd54321));
    pulse_tick(32'd54321);
    drain("reset_mid");
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_valid = 0;
    test_reset();
    test_basic();
    test_values();
    test_pending();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
